// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the FIFO read-port arbiter.
//   state_t    : two-state burst FSM encoding
//   NUM_REQ    : number of consumers sharing the read port
//   DATA_W_DEF : default FIFO read-data width
//   LEN_W_DEF  : default burst-length field width (field k = k+1 beats)
package rd_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int NUM_REQ    = 2;
   localparam int DATA_W_DEF = 8;
   localparam int LEN_W_DEF  = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   i_req      : per-consumer request
//   i_last_gnt : one-hot of the consumer granted most recently
//   o_winner   : one-hot winner (zero when nobody requests)
module rr_arb2
   import rd_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_last_gnt,
   output logic [NUM_REQ-1:0] o_winner
);

   always_comb begin
      o_winner = '0;
      case (i_req)
         2'b01:   o_winner = 2'b01;
         2'b10:   o_winner = 2'b10;
         // contention: whoever did not win last time goes first
         2'b11:   o_winner = i_last_gnt[0] ? 2'b10 : 2'b01;
         default: o_winner = '0;
      endcase
   end

endmodule

// File: rtl/rd_port_arbiter.sv
// Shares one FIFO read port between two burst consumers.
//   rd_clk / rd_rst          : read-domain clock, async active-high reset
//   fifo_empty, fifo_rd_data : FIFO read side; fifo_rd_en pops one word
//   req, req_len0/1          : burst requests and lengths (field k = k+1 beats)
//   gnt                      : registered one-hot grant
//   m_valid/m_ready/m_last   : per-consumer handshake, m_data shared
//   busy                     : high while a burst is in progress
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; a pending request is arbitrated and latched here
// BURST | gnt owns the port until the beat with beat_cnt==len_q pops
module rd_port_arbiter
   import rd_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                rd_clk,
   input  logic                rd_rst,
   input  logic                fifo_empty,
   input  logic [DATA_W-1:0]   fifo_rd_data,
   output logic                fifo_rd_en,
   input  logic [NUM_REQ-1:0]  req,
   input  logic [LEN_W-1:0]    req_len0,
   input  logic [LEN_W-1:0]    req_len1,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [NUM_REQ-1:0]  m_valid,
   input  logic [NUM_REQ-1:0]  m_ready,
   output logic [DATA_W-1:0]   m_data,
   output logic [NUM_REQ-1:0]  m_last,
   output logic                busy
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   r_last_gnt;
   logic [LEN_W-1:0]     r_len_q;
   logic [LEN_W-1:0]     r_beat_cnt;
   logic [NUM_REQ-1:0]   w_winner;
   logic                 w_grant_load;
   logic                 w_pop;
   logic                 w_last_beat;
   logic [NUM_REQ-1:0]   w_valid;

   rr_arb2 u_rr_arb2 (
      .i_req      (req),
      .i_last_gnt (r_last_gnt),
      .o_winner   (w_winner)
   );

   assign w_last_beat = (r_beat_cnt == r_len_q);

   always_comb begin
      w_valid = '0;
      if (r_state == BURST) begin
         w_valid = r_gnt & {NUM_REQ{~fifo_empty}};
      end
   end

   // only the granted lane can be valid, so at most one pop per cycle
   assign w_pop = |(w_valid & m_ready);

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_state_nxt  = BURST;
               w_grant_load = 1'b1;
            end
         end
         BURST: begin
            if (w_pop && w_last_beat) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_len_q    <= '0;
         r_beat_cnt <= '0;
         // pretend consumer 1 won last so consumer 0 has first priority
         r_last_gnt <= 2'b10;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_load) begin
            r_gnt      <= w_winner;
            r_last_gnt <= w_winner;
            r_len_q    <= w_winner[1] ? req_len1 : req_len0;
            r_beat_cnt <= '0;
         end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            if (w_last_beat) begin
               r_gnt <= '0;
            end
         end
      end
   end

   assign gnt        = r_gnt;
   assign m_valid    = w_valid;
   assign fifo_rd_en = w_pop;
   assign m_last     = w_valid & {NUM_REQ{w_last_beat}};
   assign m_data     = fifo_rd_data;
   assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_rd_port_arbiter.sv
module tb_rd_port_arbiter;

   localparam int DW = 8;
   localparam int LW = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst;
   logic          fifo_empty;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_en;
   logic [1:0]    req;
   logic [LW-1:0] req_len0;
   logic [LW-1:0] req_len1;
   logic [1:0]    gnt;
   logic [1:0]    m_valid;
   logic [1:0]    m_ready;
   logic [DW-1:0] m_data;
   logic [1:0]    m_last;
   logic          busy;

   rd_port_arbiter #(.DATA_W(DW), .LEN_W(LW)) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .req          (req),
      .req_len0     (req_len0),
      .req_len1     (req_len1),
      .gnt          (gnt),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .busy         (busy)
   );

   always #5 rd_clk = ~rd_clk;

   typedef struct {
      logic [1:0]    req;
      logic [LW-1:0] len0;
      logic [LW-1:0] len1;
      logic          empty;
      logic [1:0]    ready;
      logic [1:0]    gnt;
      logic [1:0]    valid;
      logic          rd_en;
      logic [1:0]    last;
      logic          busy;
   } vec_t;

   vec_t tbl[$];

   int n_checks = 0;
   int n_pass   = 0;
   int dut_pops = 0;
   bit last_pop_seen = 0;

   // reference model: owner (-1 = none), beats still to deliver, last winner
   int m_owner;
   int m_left;
   int m_lastw;

   function automatic vec_t mk(logic [1:0] r, int l0, int l1, logic e, logic [1:0] rdy,
                               logic [1:0] g, logic [1:0] v, logic en, logic [1:0] l, logic b);
      vec_t t;
      t.req = r; t.len0 = LW'(l0); t.len1 = LW'(l1); t.empty = e; t.ready = rdy;
      t.gnt = g; t.valid = v; t.rd_en = en; t.last = l; t.busy = b;
      return t;
   endfunction

   task automatic check(string name, logic [1:0] eg, logic [1:0] ev, logic een,
                        logic [1:0] el, logic eb);
      n_checks++;
      if (gnt === eg && m_valid === ev && fifo_rd_en === een && m_last === el &&
          busy === eb && m_data === fifo_rd_data) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got gnt=%b valid=%b rd_en=%b last=%b busy=%b data=%h, exp gnt=%b valid=%b rd_en=%b last=%b busy=%b data=%h",
                  name, $time, gnt, m_valid, fifo_rd_en, m_last, busy, m_data,
                  eg, ev, een, el, eb, fifo_rd_data);
      end
   endtask

   task automatic check_int(string name, int got, int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, exp %0d", name, got, exp);
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_left  = 0;
      m_lastw = 1;
   endfunction

   function automatic void model_exp(output logic [1:0] eg, output logic [1:0] ev,
                                     output logic een, output logic [1:0] el, output logic eb);
      eg = 2'b00; ev = 2'b00; een = 1'b0; el = 2'b00; eb = 1'b0;
      if (m_owner >= 0) begin
         eg = (m_owner == 1) ? 2'b10 : 2'b01;
         eb = 1'b1;
         if (!fifo_empty) ev = eg;
         een = |(ev & m_ready);
         if (ev != 2'b00 && m_left == 1) el = ev;
      end
   endfunction

   function automatic void model_update();
      logic [1:0] eg, ev, el;
      logic een, eb;
      int w;
      model_exp(eg, ev, een, el, eb);
      if (m_owner < 0) begin
         if (req != 2'b00) begin
            if (req == 2'b11) w = 1 - m_lastw;
            else              w = req[1] ? 1 : 0;
            m_owner = w;
            m_lastw = w;
            m_left  = ((w == 1) ? int'(req_len1) : int'(req_len0)) + 1;
         end
      end else if (een) begin
         m_left--;
         if (m_left == 0) m_owner = -1;
      end
   endfunction

   task automatic observe();
      if (fifo_rd_en === 1'b1) dut_pops++;
      if (fifo_rd_en === 1'b1 && m_last != 2'b00) last_pop_seen = 1;
   endtask

   task automatic tick();
      @(posedge rd_clk);
      model_update();
      #1;
   endtask

   task automatic step(string name);
      logic [1:0] eg, ev, el;
      logic een, eb;
      @(negedge rd_clk);
      model_exp(eg, ev, een, el, eb);
      check(name, eg, ev, een, el, eb);
      observe();
      tick();
   endtask

   task automatic apply_reset();
      req    = 2'b00;
      rd_rst = 1'b1;
      #1;
      check("in_reset", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
      repeat (2) @(posedge rd_clk);
      @(negedge rd_clk);
      rd_rst = 1'b0;
      model_reset();
      @(posedge rd_clk);
      #1;
   endtask

   initial begin
      rd_rst       = 1'b1;
      fifo_empty   = 1'b0;
      fifo_rd_data = '0;
      req          = 2'b00;
      req_len0     = '0;
      req_len1     = '0;
      m_ready      = 2'b11;
      model_reset();

      // single burst of 4, then round-robin with 1-beat bursts
      tbl.push_back(mk(2'b01, 3, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b01, 3, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b00, 1));
      tbl.push_back(mk(2'b01, 3, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b00, 1));
      tbl.push_back(mk(2'b00, 3, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b00, 1));
      tbl.push_back(mk(2'b00, 3, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b01, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b10, 2'b10, 1, 2'b10, 1));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b01, 1));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b10, 2'b10, 1, 2'b10, 1));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b11, 0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b01, 1));
      // burst of 4 with two empty cycles; len change after grant ignored
      tbl.push_back(mk(2'b01, 3, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 0, 1, 2'b11, 2'b01, 2'b00, 0, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 0, 1, 2'b11, 2'b01, 2'b00, 0, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b01, 2'b01, 1, 2'b01, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      // grant issued while FIFO is empty
      tbl.push_back(mk(2'b10, 0, 1, 1, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));
      tbl.push_back(mk(2'b00, 0, 1, 1, 2'b11, 2'b10, 2'b00, 0, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 1, 0, 2'b11, 2'b10, 2'b10, 1, 2'b00, 1));
      tbl.push_back(mk(2'b00, 0, 1, 0, 2'b11, 2'b10, 2'b10, 1, 2'b10, 1));
      tbl.push_back(mk(2'b00, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0));

      apply_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         req          = tbl[i].req;
         req_len0     = tbl[i].len0;
         req_len1     = tbl[i].len1;
         fifo_empty   = tbl[i].empty;
         m_ready      = tbl[i].ready;
         fifo_rd_data = DW'($urandom);
         @(negedge rd_clk);
         check($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].valid, tbl[i].rd_en,
               tbl[i].last, tbl[i].busy);
         observe();
         tick();
      end
      check_int("table_pops", dut_pops, 14);

      // backpressure on consumer 1 while its request drops mid-burst
      apply_reset();
      req = 2'b10; req_len1 = 4'd7; m_ready = 2'b11; fifo_empty = 1'b0;
      dut_pops = 0; last_pop_seen = 0;
      step("bp_grant");
      step("bp_beat0");
      step("bp_beat1");
      req = 2'b00; m_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         step("bp_stall");
      end
      check_int("bp_stall_pops", dut_pops, 2);
      m_ready = 2'b11;
      for (int i = 0; i < 20 && !last_pop_seen; i++) begin
         step("bp_resume");
      end
      check_int("bp_last_seen", int'(last_pop_seen), 1);
      check_int("bp_total_pops", dut_pops, 8);
      step("bp_after");

      // reset in the middle of an 8-beat burst
      apply_reset();
      req = 2'b01; req_len0 = 4'd7;
      dut_pops = 0;
      step("rst_grant");
      step("rst_beat0");
      step("rst_beat1");
      #2 rd_rst = 1'b1;
      #1 check("async_reset", 2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
      check_int("rst_pops", dut_pops, 2);
      apply_reset();
      req = 2'b11; req_len0 = 4'd0; req_len1 = 4'd0;
      step("rst_rearb_idle");
      @(negedge rd_clk);
      check("rst_first_grant", 2'b01, 2'b01, 1'b1, 2'b01, 1'b1);
      observe();
      tick();

      // randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         req          = 2'($urandom_range(0, 3));
         req_len0     = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 3));
         req_len1     = ($urandom_range(0, 3) == 0) ? LW'($urandom) : LW'($urandom_range(0, 3));
         fifo_empty   = ($urandom_range(0, 4) == 0);
         m_ready[0]   = ($urandom_range(0, 3) != 0);
         m_ready[1]   = ($urandom_range(0, 3) != 0);
         fifo_rd_data = DW'($urandom);
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rd_port_arbiter.md
RD_PORT_ARBITER -- requirements
Module: rd_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, as the FIFO read-data width.
REQ-002 The block SHALL have parameter LEN_W, default 4, as the burst-length field width; a field value k means k+1 beats (1..16).
REQ-003 Port: rd_clk  input  1  the single clock, the FIFO read-domain clock.
REQ-004 Port: rd_rst  input  1  asynchronous reset, active-high.
REQ-005 Port: fifo_empty  input  1  FIFO read-side empty flag, registered in the rd_clk domain.
REQ-006 Port: fifo_rd_data  input  DATA_W  FIFO word at the current read address, valid whenever fifo_empty=0.
REQ-007 Port: fifo_rd_en  output  1  pop strobe to the FIFO read pointer.
REQ-008 Port: req  input  2  per-consumer burst request, level-sensitive.
REQ-009 Port: req_len0 / req_len1  input  LEN_W each  burst length (encoded k+1) for consumer 0 / 1.
REQ-010 Port: gnt  output  2  one-hot grant, registered.
REQ-011 Port: m_valid  output  2  per-consumer data valid.
REQ-012 Port: m_ready  input  2  per-consumer data ready.
REQ-013 Port: m_data  output  DATA_W  shared data bus, equal to fifo_rd_data.
REQ-014 Port: m_last  output  2  per-consumer final-beat marker.
REQ-015 Port: busy  output  1  high while the FSM is in BURST.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-017 In IDLE with req!=0, the block SHALL pick a winner with a round-robin policy, register gnt, latch the winner's length into len_q, clear beat_cnt, and enter BURST on the next edge.
REQ-018 Round-robin: with both requesting, the consumer not granted most recently SHALL win; after reset, consumer 0 SHALL have priority.
REQ-019 In BURST, m_valid[g] SHALL equal ~fifo_empty for the granted index g, and m_valid of the other consumer SHALL be 0.
REQ-020 fifo_rd_en SHALL equal m_valid[g] & m_ready[g], so at most one pop occurs per cycle.
REQ-021 m_data SHALL pass fifo_rd_data through combinationally, with zero latency.
REQ-022 Each pop SHALL increment beat_cnt (LEN_W bits).
REQ-023 m_last[g] SHALL equal m_valid[g] & (beat_cnt==len_q).
REQ-024 A pop with m_last SHALL return the FSM to IDLE and clear gnt, giving exactly one dead cycle between bursts.
REQ-025 fifo_empty=1 mid-burst SHALL stall with no pop; the burst resumes when data returns.
REQ-026 m_ready low mid-burst SHALL stall with no pop.
REQ-027 A req deassertion mid-burst SHALL be ignored, and the burst SHALL complete its full length.
REQ-028 req_len changes after the grant edge SHALL be ignored.
REQ-029 With req!=0 in IDLE and fifo_empty=1, the grant SHALL still be issued; m_valid stays 0 until data arrives.
REQ-030 In IDLE, fifo_rd_en, m_valid and m_last SHALL all be 0.

Reset
REQ-031 rd_rst=1 SHALL force state IDLE, gnt=0, beat_cnt=0, len_q=0 and round-robin priority to consumer 0, asynchronously.
REQ-032 While rd_rst=1, fifo_rd_en, m_valid, m_last and busy SHALL read 0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst with no further pops; after release, arbitration restarts from IDLE.

Structure
REQ-034 Package rd_arb_pkg SHALL hold the state enum (IDLE, BURST), NUM_REQ=2, and the DATA_W/LEN_W defaults.
REQ-035 The round-robin pick SHALL live in sub-module rr_arb2 (inputs: req, last-grant; output: one-hot winner; purely combinational).
REQ-036 The FSM, counters and output gating SHALL stay in rd_port_arbiter.

Verification
REQ-037 Single burst: req=01, req_len0=3, fifo non-empty, m_ready=11 -> gnt=01 one cycle later; 4 pops on consecutive cycles; m_last[0] on the 4th pop; IDLE after.
REQ-038 Round-robin: req=11 held, both lengths 0 -> grants alternate 01,10,01,10, each 1 beat, with one idle cycle between grants.
REQ-039 Empty stall: burst of 4, fifo_empty=1 for cycles 2-3 of the burst -> fifo_rd_en=0 during those cycles; total pops still 4; m_last only on the 4th pop.
REQ-040 Backpressure and request drop: m_ready[1]=0 for 5 cycles mid-burst while req[1] deasserts -> no pops while stalled; burst finishes all beats after m_ready returns.
REQ-041 Reset mid-burst: rd_rst pulse after 2 of 8 beats -> outputs 0 asynchronously; after release with req=11, consumer 0 is granted first.
